// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, reset vector, PC increment and the bubble encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned       PC_STEP  = 4;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs; flush empties it and beats push and pop.
module fetch_fifo #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        do_push    = push & ~flush;
        do_pop     = pop & ~empty & ~flush;
        count      = count_q;
        head_pc    = pc_mem_q[rd_ptr_q];
        head_instr = instr_mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                pc_mem_q[wr_ptr_q]    <= push_pc;
                instr_mem_q[wr_ptr_q] <= push_instr;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-cycle reads to instruction memory and buffers the
// returned words for decode, handling stalls and branch redirects.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W    = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               enable,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic [ADDR_W-1:0] req_pc_d;
    logic              inflight_q;
    logic              inflight_d;
    logic              discard_q;
    logic              discard_d;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    fetch_fifo #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_pc    (req_pc_q),
        .push_instr (imem_rdata),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    always_comb begin
        if_valid = ~empty;
        pop      = if_valid & id_ready;
        push     = inflight_q & ~discard_q;

        // Credit check: every slot is either occupied or reserved by the read in flight.
        occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue     = enable & ~redirect_valid & ~clear &
                    (occupancy < (CNT_W+1)'(FIFO_DEPTH));

        imem_rd_en = issue;
        imem_addr  = pc_q;

        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        discard_d  = 1'b0;

        if (redirect_valid) begin
            pc_d      = redirect_pc;
            // The response landing this cycle is already killed by the flush; discard only
            // guards the cycle after.
            discard_d = inflight_q;
        end else if (issue) begin
            pc_d     = pc_q + ADDR_W'(PC_STEP);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    push_never_full: assert property (@(posedge clk) disable iff (clear) !(push && full))
        else $error("fetch buffer overflow");

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the 32-bit CPU. It sits directly upstream of decode/execute and produces the instruction stream that the core consumes.
- Holds the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO.
- Hands words to decode over a valid/ready handshake.
- Absorbs decode stalls and branch redirects without losing or duplicating instructions.

Parameters:
ADDR_W, 32, PC and instruction-memory address width
INSTR_W, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value after clear
FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2

Ports:
clk  in  1  system clock, all state updates on rising edge
clear  in  1  synchronous active-high reset
enable  in  1  run enable; 0 = issue no new fetches
imem_rd_en  out  1  instruction memory read strobe (combinational from state)
imem_addr  out  ADDR_W  read address, equals current PC
imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_rd_en
redirect_valid  in  1  branch/jump taken pulse from execute
redirect_pc  in  ADDR_W  new fetch target
if_valid  out  1  head of FIFO holds an instruction
if_instr  out  INSTR_W  head instruction
if_pc  out  ADDR_W  PC of head instruction
id_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset (clear=1 at an edge):
  - pc=RESET_PC; FIFO empty; inflight=0; discard=0.
  - Consequently if_valid=0, imem_rd_en=0, and if_instr/if_pc read as 0.
  - clear overrides every other input in the same cycle.
- Pop:
  - pop = if_valid & id_ready.
  - On pop, if_instr and if_pc advance to the next entry on the following cycle.
- Issue:
  - imem_rd_en = enable & ~redirect_valid & ~clear & (count + inflight - pop < FIFO_DEPTH).
  - On issue: inflight<=1, req_pc<=pc, pc<=pc+4. PC wraps modulo 2^ADDR_W with no flag.
  - This sustains one instruction per cycle while decode is ready.
- Response:
  - In the cycle after an issue, imem_rdata and req_pc are pushed into the FIFO, unless discard=1.
  - If discard=1, the word is dropped and discard clears.
  - inflight clears unless a new issue occurs in the same cycle.
  - The credit rule guarantees the FIFO never overflows. An assertion must check push & full is never true.
- Redirect (redirect_valid=1):
  - pc<=redirect_pc; FIFO flushed; any pop that cycle is ignored.
  - No issue in the redirect cycle.
  - discard<=inflight, so a response already in flight is dropped next cycle.
  - The first fetch of redirect_pc issues the following cycle if enable=1.
  - Redirect-to-redirect on consecutive cycles: the last target wins; no stale word may reach the output.
- enable=0:
  - No new issue. An outstanding response still lands in the FIFO.
  - The FIFO keeps draining to decode. PC holds.
- FIFO empty: if_valid=0, and if_instr/if_pc hold the last popped values (don't-care).
- FIFO full with id_ready=0: no issue; contents and PC hold indefinitely.
- Latency:
  - Empty pipe: issue at cycle N, if_valid at cycle N+2 (memory cycle, then FIFO register).
  - Redirect at N: target visible on if_valid at N+3.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and INSTR_W constants.
  - RESET_PC.
  - PC_STEP=4.
  - NOP encoding, used by decode for bubbles.
- One natural sub-module, fetch_fifo: a synchronous FIFO of {pc, instr}.
  - Inputs: push, pop, flush (flush beats push and pop).
  - Outputs: count, empty, full, head data.
- instr_fetch holds the PC, inflight/discard flags and the issue logic.

Test Plan:
- Reset then enable=1, id_ready=1, memory holds word = 0xA000_0000 | addr:
  - if_valid rises 2 cycles after the first rd_en.
  - if_pc runs 0x0,0x4,0x8,… on consecutive cycles, with if_instr matching.
- Stall: id_ready=0 for 5 cycles mid-stream:
  - FIFO fills to 2 and imem_rd_en drops.
  - On release, PCs continue with no gap or duplicate (e.g. 0x10,0x14,0x18).
- Redirect while a fetch is in flight: redirect_pc=0x100:
  - The old in-flight word is never presented.
  - The next if_pc seen is 0x100, 3 cycles after the redirect.
- Back-to-back redirects (0x200 then 0x300):
  - Only 0x300,0x304,… appear; 0x200 never reaches the output.
- enable dropped during streaming:
  - The outstanding word is still delivered and the FIFO drains.
  - PC holds; re-enabling resumes at the held PC.
- clear asserted mid-stream with redirect_valid=1 the same cycle:
  - Next cycle if_valid=0 and imem_rd_en=0.
  - Fetch restarts at RESET_PC=0x0, not at the redirect target.
- Wrap: redirect to 0xFFFF_FFFC:
  - Next fetched PC is 0x0000_0000.
